// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide controller:
// operation encodings and the controller state enumeration.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    FIX
  } state_t;

endpackage

// File: rtl/hilo_muldiv_ctrl.sv
// Iterative MIPS-style multiply/divide unit with HI/LO registers,
// mthi/mtlo writes, mfhi/mflo reads and a pipeline stall output.
module hilo_muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             wr_en,
  input  logic             wr_sel,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic             rd_sel,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             div_zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t             state, next_state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH:0]     acc;
  logic [WIDTH-1:0]   shreg;
  logic [WIDTH-1:0]   opnd_b;
  logic [WIDTH-1:0]   hi, lo;
  logic               is_div, neg_res, neg_rem, dz;

  logic               signed_op, in1_neg, in2_neg, in2_zero, last_iter;
  logic [WIDTH-1:0]   mag1, mag2;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // Operands are reduced to magnitudes; result signs are applied in FIX.
  always_comb begin
    signed_op = ~op[0];
    in1_neg   = signed_op & in1[WIDTH-1];
    in2_neg   = signed_op & in2[WIDTH-1];
    mag1      = in1_neg ? -in1 : in1;
    mag2      = in2_neg ? -in2 : in2;
    in2_zero  = (in2 == '0);
    last_iter = (cnt == CNT_W'(WIDTH - 1));
    mul_sum   = acc + (shreg[0] ? {1'b0, opnd_b} : '0);
    div_shift = {acc[WIDTH-1:0], shreg[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_b};
    prod      = {acc[WIDTH-1:0], shreg};
    prod_fix  = neg_res ? -prod : prod;
    quo_fix   = neg_res ? -shreg : shreg;
    rem_fix   = neg_rem ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // A zero divisor skips iteration entirely and goes straight to FIX.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (start) begin
        if (op[1] && in2_zero) next_state = FIX;
        else if (op[1])        next_state = DIV;
        else                   next_state = MUL;
      end
      MUL:     if (last_iter) next_state = FIX;
      DIV:     if (last_iter) next_state = FIX;
      FIX:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      acc      <= '0;
      shreg    <= '0;
      opnd_b   <= '0;
      hi       <= '0;
      lo       <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      dz       <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            cnt     <= '0;
            acc     <= '0;
            shreg   <= mag1;
            opnd_b  <= mag2;
            is_div  <= op[1];
            neg_res <= in1_neg ^ in2_neg;
            neg_rem <= in1_neg;
            dz      <= op[1] & in2_zero;
          end else if (wr_en) begin
            if (wr_sel) hi <= wr_data;
            else        lo <= wr_data;
          end
        end
        MUL: begin
          acc   <= {1'b0, mul_sum[WIDTH:1]};
          shreg <= {mul_sum[0], shreg[WIDTH-1:1]};
          cnt   <= cnt + 1'b1;
        end
        DIV: begin
          // A set top bit of the trial difference means a borrow: restore.
          if (!div_diff[WIDTH]) begin
            acc   <= div_diff;
            shreg <= {shreg[WIDTH-2:0], 1'b1};
          end else begin
            acc   <= div_shift;
            shreg <= {shreg[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          done     <= 1'b1;
          div_zero <= dz;
          if (!dz) begin
            if (is_div) begin
              lo <= quo_fix;
              hi <= rem_fix;
            end else begin
              {hi, lo} <= prod_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy    = (state != IDLE);
  assign stall   = rd_en & busy;
  assign rd_data = rd_sel ? hi : lo;

endmodule
